uart_bus_master: RTL and testbench

- Serial debug/loader bridge: receives command frames on a UART line and acts as initiator on the 16-bit-address / 8-bit-data memory bus.
- It is the other end of the bus that UART and other peripherals respond on.
- Lets a host PC peek and poke memory and peripherals, or load program RAM, while the CPU is held off via a request/grant handshake.
- Reuses the codebase rx/tx serial cores for the line side.

---
 rtl/uart_bus_master_pkg.sv | 35 +++
 rtl/uart_frame_timer.sv | 29 ++
 rtl/uart_rx.sv | 90 +++++++++
 rtl/uart_tx.sv | 47 ++++
 rtl/uart_bus_master.sv | 171 +++++++++++++++++
 tb/tb_uart_bus_master.sv | 280 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_bus_master_pkg.sv
// Shared constants and FSM encoding for the UART-to-bus bridge.
package uart_bus_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMER_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR_HI   = 4'd1,
    ST_ADDR_LO   = 4'd2,
    ST_DATA      = 4'd3,
    ST_REQ       = 4'd4,
    ST_ACCESS    = 4'd5,
    ST_RD_WAIT   = 4'd6,
    ST_SEND      = 4'd7,
    ST_SEND_WAIT = 4'd8
  } state_t;

  // States in which incoming bytes are consumed from the rx core.
  function automatic logic is_rx_state(input state_t s);
    return (s == ST_IDLE) || (s == ST_ADDR_HI) || (s == ST_ADDR_LO) || (s == ST_DATA);
  endfunction

  // States in which the inter-byte timeout counter runs.
  function automatic logic is_timed_state(input state_t s);
    return (s == ST_ADDR_HI) || (s == ST_ADDR_LO) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte idle counter; flags expiry after TIMEOUT clocks without a byte.
module uart_frame_timer
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_expired_c
);

  logic [TIMER_W-1:0] cnt;

  // Count idle clocks while running, saturating at TIMEOUT.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (!i_run || i_clr) begin
      cnt <= '0;
    end else if (cnt != TIMER_W'(TIMEOUT)) begin
      cnt <= cnt + TIMER_W'(1);
    end
  end

  assign o_expired_c = i_run && (cnt == TIMER_W'(TIMEOUT));

endmodule

// File: rtl/uart_rx.sv
// UART receiver core: 8N1, BAUD_DIV clocks per bit, byte held until acknowledged.
module uart_rx #(
  parameter int unsigned BAUD_DIV = 128
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_ack,
  output logic [7:0] o_data,
  output logic       o_avail,
  output logic       o_err
);

  localparam int unsigned HALF = BAUD_DIV / 2;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t   state;
  logic [1:0]  rx_sync;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        rx_in;

  assign rx_in = rx_sync[1];

  // Line synchroniser, bit sampler and holding register with overrun/framing flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state   <= R_IDLE;
      rx_sync <= 2'b11;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      o_data  <= 8'd0;
      o_avail <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], i_rx};
      if (i_ack) begin
        o_avail <= 1'b0;
        o_err   <= 1'b0;
      end
      case (state)
        R_IDLE: begin
          if (!rx_in) begin
            cnt   <= 16'd0;
            state <= R_START;
          end
        end
        R_START: begin
          if (cnt == 16'(HALF - 1)) begin
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            state   <= rx_in ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        R_DATA: begin
          if (cnt == 16'(BAUD_DIV - 1)) begin
            cnt   <= 16'd0;
            shreg <= {rx_in, shreg[7:1]};
            if (bit_idx == 3'd7) state <= R_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        R_STOP: begin
          if (cnt == 16'(BAUD_DIV - 1)) begin
            cnt   <= 16'd0;
            state <= R_IDLE;
            if (rx_in) begin
              o_data  <= shreg;
              o_avail <= 1'b1;
              if (o_avail && !i_ack) o_err <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter core: 8N1, BAUD_DIV clocks per bit, ready when idle.
module uart_tx #(
  parameter int unsigned BAUD_DIV = 128
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_go,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_ready
);

  logic [8:0]  shreg;
  logic [3:0]  nbits;
  logic [15:0] cnt;

  // Start bit on go, then 8 data bits LSB first and a stop bit, each BAUD_DIV clocks.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_tx    <= 1'b1;
      o_ready <= 1'b1;
      shreg   <= 9'd0;
      nbits   <= 4'd0;
      cnt     <= 16'd0;
    end else if (o_ready) begin
      if (i_go) begin
        o_tx    <= 1'b0;
        shreg   <= {1'b1, i_data};
        nbits   <= 4'd9;
        cnt     <= 16'd0;
        o_ready <= 1'b0;
      end
    end else if (cnt == 16'(BAUD_DIV - 1)) begin
      cnt <= 16'd0;
      if (nbits == 4'd0) begin
        o_ready <= 1'b1;
      end else begin
        o_tx  <= shreg[0];
        shreg <= {1'b0, shreg[8:1]};
        nbits <= nbits - 4'd1;
      end
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART command bridge acting as initiator on the 16-bit address / 8-bit data bus.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 128,
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_req,
  input  logic        i_gnt,
  output logic [15:0] o_addr,
  output logic [7:0]  o_data,
  output logic        o_we,
  input  logic [7:0]  i_data,
  output logic        o_err
);

  // Index of the last RD_WAIT cycle; read data is sampled at its closing edge.
  localparam int unsigned LAT_LAST = (READ_LAT > 1) ? (READ_LAT - 2) : 0;

  state_t      state;
  logic        is_write;
  logic [2:0]  lat_cnt;
  logic [7:0]  tx_byte;
  logic        tx_go;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_avail;
  logic        rx_err;
  logic        rx_ack_c;
  logic        timer_run_c;
  logic        timer_expired_c;

  assign rx_ack_c    = is_rx_state(state) && (rx_avail || rx_err);
  assign timer_run_c = is_timed_state(state);

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_rx    (i_rx),
    .i_ack   (rx_ack_c),
    .o_data  (rx_data),
    .o_avail (rx_avail),
    .o_err   (rx_err)
  );

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_go    (tx_go),
    .i_data  (tx_byte),
    .o_tx    (o_tx),
    .o_ready (tx_ready)
  );

  uart_frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_run       (timer_run_c),
    .i_clr       (rx_ack_c),
    .o_expired_c (timer_expired_c)
  );

  // Frame decode, bus access sequencing and response transmission.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state    <= ST_IDLE;
      o_req    <= 1'b0;
      o_we     <= 1'b0;
      o_addr   <= 16'd0;
      o_data   <= 8'd0;
      o_err    <= 1'b0;
      is_write <= 1'b0;
      lat_cnt  <= 3'd0;
      tx_byte  <= 8'd0;
      tx_go    <= 1'b0;
    end else begin
      o_we  <= 1'b0;
      tx_go <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_err) begin
            o_err <= 1'b1;
          end else if (rx_avail) begin
            if (rx_data == CMD_WR) begin
              is_write <= 1'b1;
              state    <= ST_ADDR_HI;
            end else if (rx_data == CMD_RD) begin
              is_write <= 1'b0;
              state    <= ST_ADDR_HI;
            end else begin
              o_err   <= 1'b1;
              tx_byte <= RSP_NAK;
              state   <= ST_SEND;
            end
          end
        end
        ST_ADDR_HI, ST_ADDR_LO, ST_DATA: begin
          if (rx_err) begin
            o_err <= 1'b1;
            state <= ST_IDLE;
          end else if (rx_avail) begin
            if (state == ST_ADDR_HI) begin
              o_addr[15:8] <= rx_data;
              state        <= ST_ADDR_LO;
            end else if (state == ST_ADDR_LO) begin
              o_addr[7:0] <= rx_data;
              if (is_write) begin
                state <= ST_DATA;
              end else begin
                o_req <= 1'b1;
                state <= ST_REQ;
              end
            end else begin
              o_data <= rx_data;
              o_req  <= 1'b1;
              state  <= ST_REQ;
            end
          end else if (timer_expired_c) begin
            o_err <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (i_gnt) begin
            o_we    <= is_write;
            lat_cnt <= 3'd0;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (is_write) begin
            o_req   <= 1'b0;
            tx_byte <= RSP_ACK;
            state   <= ST_SEND;
          end else if (READ_LAT == 1) begin
            o_req   <= 1'b0;
            tx_byte <= i_data;
            state   <= ST_SEND;
          end else begin
            state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (lat_cnt == 3'(LAT_LAST)) begin
            o_req   <= 1'b0;
            tx_byte <= i_data;
            state   <= ST_SEND;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            tx_go <= 1'b1;
            state <= ST_SEND_WAIT;
          end
        end
        ST_SEND_WAIT: begin
          if (!tx_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Randomised frame-level bench for the UART bus bridge with a memory reference model.
module tb_uart_bus_master;

  localparam int unsigned BAUD_DIV = 16;
  localparam int unsigned READ_LAT = 2;
  localparam int unsigned TIMEOUT  = 1000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_rx  = 1'b1;
  logic        o_tx;
  logic        o_req;
  logic        i_gnt = 1'b1;
  logic [15:0] o_addr;
  logic [7:0]  o_data;
  logic        o_we;
  logic [7:0]  i_data = 8'hEE;
  logic        o_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int req_cnt = 0;
  int acc_cnt = 0;
  logic exp_err = 1'b0;

  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  bus_mem [0:65535];
  logic [7:0]  rsp_q[$];
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          wr_cyc_q[$];
  logic [7:0]  dec_b;

  uart_bus_master #(.BAUD_DIV(BAUD_DIV), .READ_LAT(READ_LAT), .TIMEOUT(TIMEOUT)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_rx   (i_rx),
    .o_tx   (o_tx),
    .o_req  (o_req),
    .i_gnt  (i_gnt),
    .o_addr (o_addr),
    .o_data (o_data),
    .o_we   (o_we),
    .i_data (i_data),
    .o_err  (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Bus-side memory device: logs writes, presents read data only in the cycle READ_LAT after access.
  initial forever begin
    @(negedge i_clk);
    if (o_req) req_cnt++;
    if (o_we) begin
      wr_addr_q.push_back(o_addr);
      wr_data_q.push_back(o_data);
      wr_cyc_q.push_back(cyc);
      bus_mem[o_addr] = o_data;
      chk("we_with_gnt", 32'(i_gnt), 32'd1);
    end
    if (o_req && (i_gnt || acc_cnt > 0)) acc_cnt++;
    else if (!o_req) acc_cnt = 0;
    i_data = (acc_cnt == int'(1 + READ_LAT)) ? bus_mem[o_addr] : 8'hEE;
  end

  // Serial decoder for the bridge's responses.
  initial forever begin
    @(negedge i_clk);
    if (i_rst && o_tx == 1'b0) begin
      repeat (BAUD_DIV / 2) @(negedge i_clk);
      for (int k = 0; k < 8; k++) begin
        repeat (BAUD_DIV) @(negedge i_clk);
        dec_b[k] = o_tx;
      end
      repeat (BAUD_DIV) @(negedge i_clk);
      chk("tx_stop_bit", 32'(o_tx), 32'd1);
      rsp_q.push_back(dec_b);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      i_rx = fr[k];
      repeat (BAUD_DIV) @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_rsp(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int k = 0; k < 4000 && !ok; k++) begin
      if (rsp_q.size() > 0) begin
        b  = rsp_q.pop_front();
        ok = 1'b1;
      end else begin
        @(posedge i_clk);
        #1;
      end
    end
  endtask

  // Send one frame and check the response, bus writes, request length and error flag.
  task automatic do_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [7:0] d,
                          input bit chk_req);
    logic [7:0] exp_rsp;
    logic [7:0] got;
    bit         ok;
    int         nwr;
    int         exp_req;
    int         exp_wr;
    nwr     = wr_addr_q.size();
    req_cnt = 0;
    send_byte(cmd);
    if (cmd == 8'h57 || cmd == 8'h52) begin
      send_byte(addr[15:8]);
      send_byte(addr[7:0]);
    end
    if (cmd == 8'h57) send_byte(d);
    if (cmd == 8'h57) begin
      ref_mem[addr] = d;
      exp_rsp = 8'h06;
      exp_req = 2;
      exp_wr  = 1;
    end else if (cmd == 8'h52) begin
      exp_rsp = ref_mem[addr];
      exp_req = 1 + int'(READ_LAT);
      exp_wr  = 0;
    end else begin
      exp_rsp = 8'h15;
      exp_req = 0;
      exp_wr  = 0;
      exp_err = 1'b1;
    end
    wait_rsp(got, ok);
    chk("rsp_seen", 32'(ok), 32'd1);
    if (ok) chk("rsp_byte", 32'(got), 32'(exp_rsp));
    chk("wr_count", 32'(wr_addr_q.size() - nwr), 32'(exp_wr));
    if (exp_wr == 1 && wr_addr_q.size() > nwr) begin
      chk("wr_addr", 32'(wr_addr_q[nwr]), 32'(addr));
      chk("wr_data", 32'(wr_data_q[nwr]), 32'(d));
    end
    if (chk_req) chk("req_cycles", 32'(req_cnt), 32'(exp_req));
    chk("err_flag", 32'(o_err), 32'(exp_err));
  endtask

  initial begin
    logic [7:0]  got;
    bit          ok;
    int          nwr;
    int          gnt_cyc;
    logic [15:0] a;
    logic [7:0]  cmd;

    for (int k = 0; k < 65536; k++) begin
      ref_mem[k] = 8'($urandom);
      bus_mem[k] = ref_mem[k];
    end
    ref_mem[16'h1234] = 8'h3C;
    bus_mem[16'h1234] = 8'h3C;

    // Reset values.
    repeat (5) @(posedge i_clk);
    #1;
    chk("rst_tx", 32'(o_tx), 32'd1);
    chk("rst_req", 32'(o_req), 32'd0);
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    i_rst = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;

    // Directed write and read.
    do_frame(8'h57, 16'h0410, 8'hA5, 1'b1);
    do_frame(8'h52, 16'h1234, 8'h00, 1'b1);

    // Write with grant withheld for 500 cycles.
    i_gnt = 1'b0;
    nwr = wr_addr_q.size();
    send_byte(8'h57);
    send_byte(8'h30);
    send_byte(8'h00);
    send_byte(8'h5A);
    ref_mem[16'h3000] = 8'h5A;
    for (int k = 0; k < 200 && !o_req; k++) begin
      @(posedge i_clk);
      #1;
    end
    chk("gnt_req_up", 32'(o_req), 32'd1);
    repeat (500) @(posedge i_clk);
    #1;
    chk("gnt_req_held", 32'(o_req), 32'd1);
    chk("gnt_no_write", 32'(wr_addr_q.size() - nwr), 32'd0);
    gnt_cyc = cyc;
    i_gnt = 1'b1;
    wait_rsp(got, ok);
    chk("gnt_rsp_seen", 32'(ok), 32'd1);
    if (ok) chk("gnt_rsp", 32'(got), 32'h06);
    chk("gnt_wr_count", 32'(wr_addr_q.size() - nwr), 32'd1);
    if (wr_addr_q.size() > nwr) begin
      chk("gnt_wr_cycle", 32'(wr_cyc_q[nwr]), 32'(gnt_cyc + 1));
      chk("gnt_wr_addr", 32'(wr_addr_q[nwr]), 32'h3000);
    end

    // Random read/write traffic over a small address window.
    for (int n = 0; n < 14; n++) begin
      cmd = ($urandom_range(0, 1) == 0) ? 8'h57 : 8'h52;
      a   = {8'h20, 4'h0, 4'($urandom_range(0, 15))};
      do_frame(cmd, a, 8'($urandom), 1'b1);
    end

    // Truncated frame times out silently.
    nwr = wr_addr_q.size();
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (900) @(posedge i_clk);
    #1;
    chk("to_err_early", 32'(o_err), 32'd0);
    repeat (200) @(posedge i_clk);
    #1;
    chk("to_err_set", 32'(o_err), 32'd1);
    exp_err = 1'b1;
    chk("to_no_write", 32'(wr_addr_q.size() - nwr), 32'd0);
    chk("to_no_rsp", 32'(rsp_q.size()), 32'd0);
    chk("to_no_req", 32'(o_req), 32'd0);
    do_frame(8'h57, 16'h4455, 8'h77, 1'b1);

    // Reset between address and data bytes.
    nwr = wr_addr_q.size();
    send_byte(8'h57);
    send_byte(8'hAB);
    send_byte(8'hCD);
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("mid_rst_tx", 32'(o_tx), 32'd1);
    chk("mid_rst_req", 32'(o_req), 32'd0);
    chk("mid_rst_addr", 32'(o_addr), 32'd0);
    chk("mid_rst_data", 32'(o_data), 32'd0);
    chk("mid_rst_err", 32'(o_err), 32'd0);
    i_rst = 1'b1;
    exp_err = 1'b0;
    repeat (3000) @(posedge i_clk);
    #1;
    chk("mid_rst_no_write", 32'(wr_addr_q.size() - nwr), 32'd0);
    chk("mid_rst_no_rsp", 32'(rsp_q.size()), 32'd0);

    // Bad command, then a normal read still works.
    do_frame(8'hFF, 16'h0000, 8'h00, 1'b1);
    do_frame(8'h52, 16'h0000, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
